// File: rtl/decode_exec_pipe.sv
// Two-entry skid buffer between decode and execute, with load-use hazard
// detection against the youngest held entry and a saturating stall counter.
module decode_exec_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned LD_BIT = 7,
  parameter int unsigned WB_BIT = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h6800_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_btarget,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [XLEN-1:0]   out_rd2,
  output logic [XLEN-1:0]   out_btarget,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic              load_use_stall,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_count
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   btarget;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } entry_t;

  entry_t      head_q, head_d, skid_q, skid_d, in_e, yng;
  logic        head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        yng_v, acc, deq;

  assign in_e = '{pc: in_pc, instr: in_instr, a: in_a, b: in_b, rd2: in_rd2,
                  btarget: in_btarget, ctrl: in_ctrl, rs1: in_rs1, rs2: in_rs2, rd: in_rd};

  // Hazard is checked against the most recently accepted entry only.
  assign yng_v = head_v_q | skid_v_q;
  assign yng   = skid_v_q ? skid_q : head_q;

  assign load_use_stall = in_valid & yng_v & yng.ctrl[LD_BIT] & yng.ctrl[WB_BIT] &
                          ((in_use_rs1 & (in_rs1 == yng.rd)) |
                           (in_use_rs2 & (in_rs2 == yng.rd)));

  assign occupancy = {1'b0, head_v_q} + {1'b0, skid_v_q};
  assign in_ready  = ~skid_v_q & ~load_use_stall & ~flush & ~rst;
  assign acc       = in_valid & in_ready;
  assign deq       = head_v_q & out_ready;

  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (deq) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (acc) begin
        head_d = in_e;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (acc) begin
      if (head_v_q) begin
        skid_d   = in_e;
        skid_v_d = 1'b1;
      end else begin
        head_d   = in_e;
        head_v_d = 1'b1;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      // A same-cycle dequeue was already taken by execute; just drop everything.
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      head_v_q    <= head_v_d;
      skid_v_q    <= skid_v_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign out_valid   = head_v_q;
  assign out_pc      = head_v_q ? head_q.pc      : '0;
  assign out_instr   = head_v_q ? head_q.instr   : NOP_INSTR;
  assign out_a       = head_v_q ? head_q.a       : '0;
  assign out_b       = head_v_q ? head_q.b       : '0;
  assign out_rd2     = head_v_q ? head_q.rd2     : '0;
  assign out_btarget = head_v_q ? head_q.btarget : '0;
  assign out_ctrl    = head_v_q ? head_q.ctrl    : '0;
  assign out_rs1     = head_v_q ? head_q.rs1     : '0;
  assign out_rs2     = head_v_q ? head_q.rs2     : '0;
  assign out_rd      = head_v_q ? head_q.rd      : '0;

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Directed bench for decode_exec_pipe: FIFO order, load-use stall, flush, reset.
module tb_decode_exec_pipe;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, in_use_rs1, in_use_rs2;
  logic [31:0] in_pc, in_instr, in_a, in_b, in_rd2, in_btarget;
  logic [15:0] in_ctrl, out_ctrl, stall_count;
  logic [3:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic        out_valid, out_ready, load_use_stall;
  logic [31:0] out_pc, out_instr, out_a, out_b, out_rd2, out_btarget;
  logic [1:0]  occupancy;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  decode_exec_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_a(in_a), .in_b(in_b), .in_rd2(in_rd2),
    .in_btarget(in_btarget), .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_a(out_a), .out_b(out_b), .out_rd2(out_rd2), .out_btarget(out_btarget),
    .out_ctrl(out_ctrl), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .load_use_stall(load_use_stall), .occupancy(occupancy), .stall_count(stall_count));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                       input logic u1, input logic u2);
    in_valid = v; in_pc = pc; in_instr = pc ^ 32'hA5A5_0000; in_a = pc + 32'd1;
    in_b = pc + 32'd2; in_rd2 = pc + 32'd3; in_btarget = pc + 32'd4;
    in_ctrl = ctrl; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b1, 32'h0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    #1; chk("rst_in_ready", 64'(in_ready), 64'd0);
    step; step;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'h6800_0000);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_stall_cnt", 64'(stall_count), 64'd0);

    // Single transfer, latency 1
    rst = 1'b0; out_ready = 1'b1;
    offer(1'b1, 32'h100, 16'h0, 4'd1, 4'd2, 4'd5, 1'b0, 1'b0);
    in_instr = 32'h1234_5678;
    #1; chk("t1_in_ready", 64'(in_ready), 64'd1);
    step;
    offer(1'b0, 32'h0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pc", 64'(out_pc), 64'h100);
    chk("t1_out_instr", 64'(out_instr), 64'h1234_5678);
    chk("t1_occ", 64'(occupancy), 64'd1);
    step;
    chk("t1_drain_occ", 64'(occupancy), 64'd0);

    // Three offers with execute stalled
    out_ready = 1'b0;
    offer(1'b1, 32'h10, 16'h0, 4'd1, 4'd2, 4'd6, 1'b0, 1'b0); step;
    offer(1'b1, 32'h14, 16'h0, 4'd1, 4'd2, 4'd7, 1'b0, 1'b0); step;
    offer(1'b1, 32'h18, 16'h0, 4'd1, 4'd2, 4'd8, 1'b0, 1'b0);
    #1;
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_occ_full", 64'(occupancy), 64'd2);
    chk("t2_head_pc", 64'(out_pc), 64'h10);
    chk("t2_head_a", 64'(out_a), 64'h11);
    chk("t2_head_rd", 64'(out_rd), 64'd6);
    out_ready = 1'b1;
    step;
    chk("t2_pc1", 64'(out_pc), 64'h14);
    chk("t2_occ1", 64'(occupancy), 64'd1);
    step;
    offer(1'b0, 32'h0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("t2_pc2", 64'(out_pc), 64'h18);
    chk("t2_btarget2", 64'(out_btarget), 64'h1C);
    chk("t2_occ2", 64'(occupancy), 64'd1);
    step;
    chk("t2_drained", 64'(out_valid), 64'd0);

    // Load-use hazard against head
    out_ready = 1'b0;
    offer(1'b1, 32'h200, 16'h0084, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0); step;
    offer(1'b1, 32'h204, 16'h0, 4'd3, 4'd9, 4'd5, 1'b1, 1'b0);
    #1;
    chk("t3_stall", 64'(load_use_stall), 64'd1);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    step;
    chk("t3_stall_cnt", 64'(stall_count), 64'd1);
    chk("t3_occ_stalled", 64'(occupancy), 64'd1);
    chk("t3_head_held", 64'(out_pc), 64'h200);
    in_use_rs1 = 1'b0;
    #1;
    chk("t3_nostall", 64'(load_use_stall), 64'd0);
    chk("t3_in_ready2", 64'(in_ready), 64'd1);
    step;
    chk("t3_occ2", 64'(occupancy), 64'd2);
    chk("t3_stall_cnt_hold", 64'(stall_count), 64'd1);
    // Youngest is now the non-load skid entry, so rd=3 must not stall
    offer(1'b1, 32'h208, 16'h0, 4'd0, 4'd3, 4'd1, 1'b0, 1'b1);
    #1; chk("t3_young_skid", 64'(load_use_stall), 64'd0);

    // Flush while full with a dequeue in the same cycle
    flush = 1'b1; out_ready = 1'b1;
    #1; chk("t4_in_ready_flush", 64'(in_ready), 64'd0);
    step;
    flush = 1'b0;
    offer(1'b0, 32'h0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_out_instr", 64'(out_instr), 64'h6800_0000);
    chk("t4_occ", 64'(occupancy), 64'd0);
    chk("t4_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("t4_stall_cnt", 64'(stall_count), 64'd1);

    // Long stall to saturate the counter
    out_ready = 1'b0;
    offer(1'b1, 32'h300, 16'h0084, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0); step;
    offer(1'b1, 32'h304, 16'h0, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    chk("t5_stall_sat", 64'(stall_count), 64'hFFFF);
    chk("t5_occ", 64'(occupancy), 64'd1);
    in_use_rs1 = 1'b0;
    step;
    chk("t5_occ_full", 64'(occupancy), 64'd2);

    // Reset beats flush and transfers
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    offer(1'b1, 32'h400, 16'h0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
    #1; chk("t6_in_ready", 64'(in_ready), 64'd0);
    step;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_instr", 64'(out_instr), 64'h6800_0000);
    chk("t6_out_pc", 64'(out_pc), 64'd0);
    chk("t6_stall_cnt", 64'(stall_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
